// File: rtl/high_bit_search_pkg.sv
// -----------------------------------------------------------------------------
// high_bit_search_pkg
// Shared definitions for the leading-one detector:
//   - clog2()   : constant function used to size the index output
//   - node_t    : result carried between merge nodes (valid + partial index)
// The partial index is sized for the widest legal word (64 bits -> 6 bits) so
// one struct type serves every level of the tree.
// -----------------------------------------------------------------------------
package high_bit_search_pkg;

  localparam int unsigned MAX_INPUT_WIDTH = 64;
  localparam int unsigned MAX_IDX_W       = 6;

  // Ceiling log2 for elaboration-time sizing; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned res;
    int unsigned acc;
    res = 0;
    acc = 1;
    while (acc < v) begin
      acc = acc << 1;
      res = res + 1;
    end
    return res;
  endfunction

  // Result of one subtree: any bit set, and where the highest one sits.
  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } node_t;

endpackage

// File: rtl/high_bit_search_node.sv
// -----------------------------------------------------------------------------
// high_bit_search_node
// 2:1 merge node of the leading-one tree. The high-side subtree wins whenever
// it found a set bit; in that case the node's own index bit (LEVEL) is set on
// top of the high child's partial index, otherwise the low child's partial
// index passes through unchanged.
// Ports:
//   i_hi  : result of the more-significant half
//   i_lo  : result of the less-significant half
//   o_res : merged result
// -----------------------------------------------------------------------------
module high_bit_search_node
  import high_bit_search_pkg::*;
#(
  parameter int unsigned LEVEL = 0
) (
  input  node_t i_hi,
  input  node_t i_lo,
  output node_t o_res
);

  localparam logic [MAX_IDX_W-1:0] LP_LEVEL_BIT = {{(MAX_IDX_W-1){1'b0}}, 1'b1} << LEVEL;

  // Merge: MSB-side subtree takes priority.
  always_comb begin
    o_res       = '0;
    o_res.valid = i_hi.valid | i_lo.valid;
    if (i_hi.valid) begin
      // Children below this level only ever populate bits under LEVEL,
      // so OR-ing in the level bit is the same as prefixing a 1.
      o_res.idx = i_hi.idx | LP_LEVEL_BIT;
    end else begin
      o_res.idx = i_lo.idx;
    end
  end

endmodule

// File: rtl/high_bit_search.sv
// -----------------------------------------------------------------------------
// high_bit_search
// Registered leading-one detector (MSB wins). Each rising edge samples
// input_data and, one cycle later, reports the index of the highest set bit,
// a one-hot mask of it, and whether any bit was set.
// Ports:
//   clk             : system clock, rising edge
//   rst_n           : asynchronous active-low reset
//   input_data      : word to search, sampled every edge
//   high_bit_idx    : index (0 = LSB) of the highest set bit; 0 when none
//   high_bit_onehot : mask with only bit high_bit_idx set; 0 when none
//   found           : 1 when the sampled word was non-zero
// -----------------------------------------------------------------------------
module high_bit_search
  import high_bit_search_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = 16,
  parameter int unsigned IDX_WIDTH   = clog2(INPUT_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INPUT_WIDTH-1:0] input_data,
  output logic [IDX_WIDTH-1:0]   high_bit_idx,
  output logic [INPUT_WIDTH-1:0] high_bit_onehot,
  output logic                   found
);

  // Tree is built over the next power of two; missing leaves read as zero.
  localparam int unsigned PAD_W   = 1 << IDX_WIDTH;
  localparam int unsigned N_NODES = 2 * PAD_W - 1;

  localparam logic [INPUT_WIDTH-1:0] LP_ONE = {{(INPUT_WIDTH-1){1'b0}}, 1'b1};

  // Heap layout: node n has children 2n+1 (high half) and 2n+2 (low half).
  // Internal nodes occupy 0..PAD_W-2, leaves PAD_W-1..2*PAD_W-2 with the
  // leftmost leaf holding the most-significant bit.
  node_t w_tree [0:N_NODES-1];

  logic                   r_found;
  logic [IDX_WIDTH-1:0]   r_idx;
  logic [INPUT_WIDTH-1:0] w_onehot;

  genvar g_j;
  genvar g_d;
  genvar g_k;

  // Leaves: one per padded bit position.
  generate
    for (g_j = 0; g_j < PAD_W; g_j = g_j + 1) begin : g_leaf
      localparam int unsigned BIT_POS = PAD_W - 1 - g_j;
      if (BIT_POS < INPUT_WIDTH) begin : g_real
        assign w_tree[PAD_W-1+g_j] = '{valid: input_data[BIT_POS], idx: '0};
      end else begin : g_pad
        assign w_tree[PAD_W-1+g_j] = '{valid: 1'b0, idx: '0};
      end
    end
  endgenerate

  // Merge levels: depth d resolves index bit IDX_WIDTH-1-d.
  generate
    for (g_d = 0; g_d < IDX_WIDTH; g_d = g_d + 1) begin : g_level
      for (g_k = 0; g_k < (1 << g_d); g_k = g_k + 1) begin : g_node
        localparam int unsigned NODE = (1 << g_d) - 1 + g_k;
        high_bit_search_node #(
          .LEVEL (IDX_WIDTH - 1 - g_d)
        ) u_node (
          .i_hi  (w_tree[2*NODE+1]),
          .i_lo  (w_tree[2*NODE+2]),
          .o_res (w_tree[NODE])
        );
      end
    end
  endgenerate

  // Result register: found and index always come from the same sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_found <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_found <= w_tree[0].valid;
      r_idx   <= w_tree[0].idx[IDX_WIDTH-1:0];
    end
  end

  // One-hot mask decoded from the registered result, so it tracks idx/found.
  always_comb begin
    w_onehot = '0;
    if (r_found) begin
      w_onehot = LP_ONE << r_idx;
    end else begin
      w_onehot = '0;
    end
  end

  assign high_bit_idx    = r_idx;
  assign high_bit_onehot = w_onehot;
  assign found           = r_found;

endmodule

// File: tb/tb_high_bit_search.sv
module tb_high_bit_search;

  logic        clk;
  logic        rst_n;
  logic [15:0] data16;
  logic [3:0]  idx16;
  logic [15:0] oh16;
  logic        found16;
  logic [11:0] data12;
  logic [3:0]  idx12;
  logic [11:0] oh12;
  logic        found12;

  int vectors;
  int miscompares;

  high_bit_search #(.INPUT_WIDTH(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .input_data      (data16),
    .high_bit_idx    (idx16),
    .high_bit_onehot (oh16),
    .found           (found16)
  );

  high_bit_search #(.INPUT_WIDTH(12)) dut12 (
    .clk             (clk),
    .rst_n           (rst_n),
    .input_data      (data12),
    .high_bit_idx    (idx12),
    .high_bit_onehot (oh12),
    .found           (found12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic exp_found, input logic [3:0] exp_idx,
                       input logic [15:0] exp_oh);
    vectors = vectors + 1;
    assert (found16 === exp_found) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s.found observed=%0b expected=%0b", tag, found16, exp_found);
    end
    vectors = vectors + 1;
    assert (idx16 === exp_idx) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s.idx observed=%0d expected=%0d", tag, idx16, exp_idx);
    end
    vectors = vectors + 1;
    assert (oh16 === exp_oh) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s.onehot observed=%h expected=%h", tag, oh16, exp_oh);
    end
  endtask

  task automatic chk12(input string tag, input logic exp_found, input logic [3:0] exp_idx,
                       input logic [11:0] exp_oh);
    vectors = vectors + 1;
    assert (found12 === exp_found) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s.found observed=%0b expected=%0b", tag, found12, exp_found);
    end
    vectors = vectors + 1;
    assert (idx12 === exp_idx) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s.idx observed=%0d expected=%0d", tag, idx12, exp_idx);
    end
    vectors = vectors + 1;
    assert (oh12 === exp_oh) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s.onehot observed=%h expected=%h", tag, oh12, exp_oh);
    end
  endtask

  // Drive a word, let it be captured, and land 1 time unit after the edge.
  task automatic step(input logic [15:0] d16, input logic [11:0] d12);
    data16 = d16;
    data12 = d12;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] mix_in  [0:9];
  logic [3:0]  mix_idx [0:9];
  logic [15:0] w1;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    data16      = 16'hFFFF;
    data12      = 12'hFFF;

    mix_in[0] = 16'h16DE; mix_idx[0] = 4'd12;
    mix_in[1] = 16'h5403; mix_idx[1] = 4'd14;
    mix_in[2] = 16'h00BE; mix_idx[2] = 4'd7;
    mix_in[3] = 16'h0F15; mix_idx[3] = 4'd11;
    mix_in[4] = 16'h87CA; mix_idx[4] = 4'd15;
    mix_in[5] = 16'h0124; mix_idx[5] = 4'd8;
    mix_in[6] = 16'h23BA; mix_idx[6] = 4'd13;
    mix_in[7] = 16'hBF76; mix_idx[7] = 4'd15;
    mix_in[8] = 16'h14DE; mix_idx[8] = 4'd12;
    mix_in[9] = 16'h7643; mix_idx[9] = 4'd14;

    // Reset held with all-ones input: outputs stay cleared.
    #2;
    chk16("reset_t0", 1'b0, 4'd0, 16'h0000);
    chk12("reset12_t0", 1'b0, 4'd0, 12'h000);
    step(16'hFFFF, 12'hFFF);
    step(16'hFFFF, 12'hFFF);
    chk16("reset_held", 1'b0, 4'd0, 16'h0000);
    chk12("reset12_held", 1'b0, 4'd0, 12'h000);

    // Release between edges; first result after the next edge.
    rst_n = 1'b1;
    step(16'hFFFF, 12'hFFF);
    chk16("reset_release", 1'b1, 4'd15, 16'h8000);
    chk12("reset12_release", 1'b1, 4'd11, 12'h800);

    // Mixed sequence, one word per cycle.
    for (int i = 0; i < 10; i++) begin
      step(mix_in[i], 12'h000);
      chk16($sformatf("mix%0d", i), 1'b1, mix_idx[i], 16'h0001 << mix_idx[i]);
    end

    // Zero word, then the lowest bit alone.
    step(16'h0000, 12'h000);
    chk16("zero", 1'b0, 4'd0, 16'h0000);
    step(16'h0001, 12'h000);
    chk16("after_zero", 1'b1, 4'd0, 16'h0001);

    // Walking one: onehot mirrors the input.
    for (int k = 0; k < 16; k++) begin
      w1 = 16'h0001 << k;
      step(w1, 12'h000);
      chk16($sformatf("walk%0d", k), 1'b1, 4'(k), w1);
    end

    // Asynchronous reset mid-stream, asserted between edges.
    chk16("pre_async", 1'b1, 4'd15, 16'h8000);
    #3;
    rst_n = 1'b0;
    #1;
    chk16("async_clear", 1'b0, 4'd0, 16'h0000);
    step(16'h0040, 12'h000);
    chk16("async_hold", 1'b0, 4'd0, 16'h0000);
    rst_n = 1'b1;
    step(16'h0040, 12'h000);
    chk16("async_release", 1'b1, 4'd6, 16'h0040);

    // Non-power-of-2 width instance.
    step(16'h0000, 12'h800);
    chk12("w12_msb", 1'b1, 4'd11, 12'h800);
    step(16'h0000, 12'h001);
    chk12("w12_lsb", 1'b1, 4'd0, 12'h001);
    step(16'h0000, 12'h000);
    chk12("w12_zero", 1'b0, 4'd0, 12'h000);
    step(16'h0000, 12'h0A5);
    chk12("w12_mid", 1'b1, 4'd7, 12'h080);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/high_bit_search.md
Name: high_bit_search

Overview:
- Registered leading-one detector (priority encoder, MSB wins) for a parameterised data word.
- Each clock it samples `input_data` and reports three things: the index of the most-significant set bit, a one-hot mask of that bit, and a flag saying whether any bit was set.
- Used as a normalisation / leading-one helper in datapath blocks.
- Encoding is a log2-depth binary tree of merge nodes, so timing scales with log2(INPUT_WIDTH).

Parameters:
- INPUT_WIDTH, 16, width of `input_data`; legal values are 2..64, and non-powers-of-2 are allowed.
- IDX_WIDTH, $clog2(INPUT_WIDTH), width of `high_bit_idx`; derived, and must not be overridden.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- input_data  input  INPUT_WIDTH  word to search; sampled every rising edge.
- high_bit_idx  output  IDX_WIDTH  index (0 = LSB) of the highest set bit of the sampled word.
- high_bit_onehot  output  INPUT_WIDTH  one-hot mask with only bit `high_bit_idx` set; all zero when nothing is found.
- found  output  1  1 when the sampled word was non-zero.

Behaviour:
- Reset: while `rst_n` = 0, all outputs are 0 (`high_bit_idx` = 0, `high_bit_onehot` = 0, `found` = 0). Reset asserts asynchronously; release is synchronised by the user.
- Latency is 1 cycle:
  - Encoding from `input_data` to the output registers is combinational.
  - The value present at rising edge N appears on the outputs immediately after edge N and is held until edge N+1.
  - No handshake: the block accepts a new word every cycle.
- Encoding: `high_bit_idx` = max{i : input_data[i] = 1}.
- Zero word:
  - `found` = 0, `high_bit_idx` = 0, `high_bit_onehot` = 0.
  - Consumers must qualify `high_bit_idx` with `found`.
- Only the MSB-most set bit counts; lower bits have no effect on any output.
- All three outputs update together from the same sample; they never mix values from different cycles.
- Non-power-of-2 INPUT_WIDTH: the tree is padded internally with zeros up to the next power of 2. Padding never produces an index ≥ INPUT_WIDTH.
- Reset mid-operation: outputs clear immediately. The first valid result appears one edge after `rst_n` deasserts.
- X or Z on `input_data` is not specified; the bench drives known values only.

Decomposition:
- Shared package high_bit_search_pkg:
  - constant function for clog2, used for IDX_WIDTH;
  - a typedef for the node result (valid bit plus partial index).
- One sub-module, high_bit_search_node, is a 2:1 merge node:
  - it takes {valid_hi, idx_hi} and {valid_lo, idx_lo};
  - valid = valid_hi | valid_lo;
  - idx = valid_hi ? {1, idx_hi} : {0, idx_lo}.
- The top level instantiates the node in a generate-built tree of log2 levels, registers the root result, and derives `high_bit_onehot` from the registered index and `found`.

Test Plan:
- Reset: hold `rst_n` = 0 and drive `input_data` = 16'hFFFF -> all outputs stay 0. Release reset -> after the next edge, `found` = 1 and `high_bit_idx` = 15.
- Mixed sequence, one word per cycle, each result 1 cycle later:
  - 16'h16DE -> 12; 16'h5403 -> 14; 16'h00BE -> 7; 16'h0F15 -> 11; 16'h87CA -> 15;
  - 16'h0124 -> 8; 16'h23BA -> 13; 16'hBF76 -> 15; 16'h14DE -> 12; 16'h7643 -> 14;
  - `found` = 1 throughout; `high_bit_onehot` = 1 << idx.
- Zero word: 16'h0000 -> `found` = 0, `high_bit_idx` = 0, `high_bit_onehot` = 0. Following it with 16'h0001 -> `found` = 1, `high_bit_idx` = 0, `high_bit_onehot` = 16'h0001.
- Walking one: 16'h0001 << k for k = 0..15 on consecutive cycles -> `high_bit_idx` = k; `high_bit_onehot` equals the input.
- Async reset mid-stream: assert `rst_n` = 0 between edges while `found` = 1 -> outputs go to 0 before the next edge and stay 0 until after release.
- Parameter sweep with INPUT_WIDTH = 12, driving 12'h800, 12'h001, 12'h000 -> idx 11 with found 1; idx 0 with found 1; found 0. `high_bit_idx` is 4 bits wide.
